// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter
// Shares one single-port data memory between two requesters:
//   r0 - multi-cycle CPU load/store path
//   r1 - program/data loader used during bring-up
// Round-robin arbitration. Each access takes IDLE -> ACCESS -> RESP. A read
// holds MemRd for RD_LAT cycles before mem_data_out is captured. A write
// holds MemWr for one cycle. The granted requester gets a one-cycle ack in
// RESP.
//
// Ports:
//   clk, reset                        clock, async active-high reset
//   rN_req/we/addr/wdata              requester N command (held until ack)
//   rN_ack, rN_rdata                  completion pulse, read data (held)
//   mem_addr, mem_data_in             memory address / write data
//   MemRd, MemWr                      memory read / write enables
//   mem_data_out                      memory read data
//   busy                              controller not in IDLE
//   grant_id                          requester currently / last granted
module data_mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              r0_req,
    input  logic              r0_we,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [DATA_W-1:0] r0_wdata,
    output logic              r0_ack,
    output logic [DATA_W-1:0] r0_rdata,
    input  logic              r1_req,
    input  logic              r1_we,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r1_wdata,
    output logic              r1_ack,
    output logic [DATA_W-1:0] r1_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data_in,
    output logic              MemRd,
    output logic              MemWr,
    input  logic [DATA_W-1:0] mem_data_out,
    output logic              busy,
    output logic              grant_id
);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        RESP   = 2'b10
    } state_t;

    // Reads stay in ACCESS for RD_LAT cycles, so the counter starts at RD_LAT-1.
    localparam logic [1:0] RD_CNT_INIT = 2'(RD_LAT - 1);

    state_t              state_r;
    state_t              state_s;
    logic [1:0]          cnt_r;
    logic                we_r;
    logic                last_grant_r;
    logic                grant_id_r;
    logic [ADDR_W-1:0]   mem_addr_r;
    logic [DATA_W-1:0]   mem_wdata_r;
    logic                mem_rd_r;
    logic                mem_wr_r;
    logic                r0_ack_r;
    logic                r1_ack_r;
    logic [DATA_W-1:0]   r0_rdata_r;
    logic [DATA_W-1:0]   r1_rdata_r;
    logic                busy_r;

    logic                pick_s;
    logic                take_s;
    logic                sel_we_s;
    logic [ADDR_W-1:0]   sel_addr_s;
    logic [DATA_W-1:0]   sel_wdata_s;
    logic                we_s;
    logic                gid_s;

    // Arbitration: a lone requester wins; on a tie the one not granted last wins.
    always_comb begin
        pick_s = 1'b0;
        if (r0_req && r1_req) begin
            pick_s = ~last_grant_r;
        end else if (r1_req) begin
            pick_s = 1'b1;
        end else begin
            pick_s = 1'b0;
        end
        take_s      = (state_r == IDLE) && (r0_req || r1_req);
        sel_we_s    = pick_s ? r1_we    : r0_we;
        sel_addr_s  = pick_s ? r1_addr  : r0_addr;
        sel_wdata_s = pick_s ? r1_wdata : r0_wdata;
        // Values that the registers will hold after this edge.
        we_s  = take_s ? sel_we_s : we_r;
        gid_s = take_s ? pick_s   : grant_id_r;
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (take_s) begin
                    state_s = ACCESS;
                end else begin
                    state_s = IDLE;
                end
            end
            ACCESS: begin
                if (we_r || (cnt_r == 2'd0)) begin
                    state_s = RESP;
                end else begin
                    state_s = ACCESS;
                end
            end
            RESP:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Grant latching, read-latency counter, read capture and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r        <= 2'd0;
            we_r         <= 1'b0;
            last_grant_r <= 1'b1;
            grant_id_r   <= 1'b0;
            mem_addr_r   <= {ADDR_W{1'b0}};
            mem_wdata_r  <= {DATA_W{1'b0}};
            mem_rd_r     <= 1'b0;
            mem_wr_r     <= 1'b0;
            r0_ack_r     <= 1'b0;
            r1_ack_r     <= 1'b0;
            r0_rdata_r   <= {DATA_W{1'b0}};
            r1_rdata_r   <= {DATA_W{1'b0}};
            busy_r       <= 1'b0;
        end else begin
            if (take_s) begin
                mem_addr_r   <= sel_addr_s;
                mem_wdata_r  <= sel_wdata_s;
                we_r         <= sel_we_s;
                grant_id_r   <= pick_s;
                last_grant_r <= pick_s;
                cnt_r        <= sel_we_s ? 2'd0 : RD_CNT_INIT;
            end
            if ((state_r == ACCESS) && !we_r) begin
                if (cnt_r != 2'd0) begin
                    cnt_r <= cnt_r - 2'd1;
                end else if (grant_id_r) begin
                    r1_rdata_r <= mem_data_out;
                end else begin
                    r0_rdata_r <= mem_data_out;
                end
            end
            // Outputs are registered from the next state so they line up with it.
            mem_rd_r <= (state_s == ACCESS) && !we_s;
            mem_wr_r <= (state_s == ACCESS) &&  we_s;
            r0_ack_r <= (state_s == RESP) && !gid_s;
            r1_ack_r <= (state_s == RESP) &&  gid_s;
            busy_r   <= (state_s != IDLE);
        end
    end

    assign mem_addr    = mem_addr_r;
    assign mem_data_in = mem_wdata_r;
    assign MemRd       = mem_rd_r;
    assign MemWr       = mem_wr_r;
    assign r0_ack      = r0_ack_r;
    assign r1_ack      = r1_ack_r;
    assign r0_rdata    = r0_rdata_r;
    assign r1_rdata    = r1_rdata_r;
    assign busy        = busy_r;
    assign grant_id    = grant_id_r;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: two instances (RD_LAT=1 and RD_LAT=3) run side by
// side, each against its own memory and its own transaction-level model. The
// model schedules each granted access as a window of cycles: ACCESS for L
// cycles, then one RESP cycle. L is 1 for a write and RD_LAT for a read. The
// next grant is possible two cycles after the window ends.
module tb_data_mem_arbiter;

    logic        clk;
    logic        reset;
    logic        mem_clr;

    logic        req_d   [2][2];
    logic        we_d    [2][2];
    logic [31:0] addr_d  [2][2];
    logic [31:0] wdata_d [2][2];
    logic        ack_o   [2][2];
    logic [31:0] rdata_o [2][2];
    logic [31:0] maddr [2];
    logic [31:0] mdin  [2];
    logic [31:0] mdout [2];
    logic        mrd   [2];
    logic        mwr   [2];
    logic        busy_o[2];
    logic        gid_o [2];
    logic [31:0] mem   [2][16];

    int vectors;
    int miscompares;
    int cyc;

    // Reference model state, per instance.
    bit          act    [2];
    int          gc     [2];
    int          tlen   [2];
    int          free_c [2];
    bit          who    [2];
    bit          twe    [2];
    logic [31:0] taddr  [2];
    logic [31:0] twd    [2];
    bit          last   [2];
    logic        exp_gid[2];
    logic [31:0] exp_addr[2];
    logic [31:0] exp_din [2];
    logic [31:0] exp_rd  [2][2];
    logic [31:0] ref_mem [2][16];
    bit          inflight[2][2];
    bit          rsp_flag[2][2];
    bit          hold    [2][2];
    bit          auto_mode;
    int          ack_seq [2][8];
    int          ack_n   [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        data_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT((g == 0) ? 1 : 3)) dut (
            .clk(clk), .reset(reset),
            .r0_req(req_d[g][0]), .r0_we(we_d[g][0]), .r0_addr(addr_d[g][0]),
            .r0_wdata(wdata_d[g][0]), .r0_ack(ack_o[g][0]), .r0_rdata(rdata_o[g][0]),
            .r1_req(req_d[g][1]), .r1_we(we_d[g][1]), .r1_addr(addr_d[g][1]),
            .r1_wdata(wdata_d[g][1]), .r1_ack(ack_o[g][1]), .r1_rdata(rdata_o[g][1]),
            .mem_addr(maddr[g]), .mem_data_in(mdin[g]), .MemRd(mrd[g]), .MemWr(mwr[g]),
            .mem_data_out(mdout[g]), .busy(busy_o[g]), .grant_id(gid_o[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Simple memories, indexed by the low address bits, read combinationally.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (mem_clr) begin
                for (int a = 0; a < 16; a++) mem[k][a] <= 32'd0;
            end else if (mwr[k]) begin
                mem[k][maddr[k][3:0]] <= mdin[k];
            end
        end
    end

    always_comb begin
        for (int k = 0; k < 2; k++) mdout[k] = mem[k][maddr[k][3:0]];
    end

    function automatic int lat_of(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            act[k] = 1'b0; free_c[k] = 0; last[k] = 1'b1; exp_gid[k] = 1'b0;
            exp_addr[k] = 32'd0; exp_din[k] = 32'd0;
            for (int i = 0; i < 2; i++) begin
                exp_rd[k][i] = 32'd0; inflight[k][i] = 1'b0; rsp_flag[k][i] = 1'b0;
            end
        end
    endtask

    task automatic check_all_zero(input string tag);
        for (int k = 0; k < 2; k++) begin
            check_eq($sformatf("%s_k%0d_busy", tag, k),  32'(busy_o[k]), 32'd0);
            check_eq($sformatf("%s_k%0d_MemRd", tag, k), 32'(mrd[k]), 32'd0);
            check_eq($sformatf("%s_k%0d_MemWr", tag, k), 32'(mwr[k]), 32'd0);
            check_eq($sformatf("%s_k%0d_ack0", tag, k),  32'(ack_o[k][0]), 32'd0);
            check_eq($sformatf("%s_k%0d_ack1", tag, k),  32'(ack_o[k][1]), 32'd0);
            check_eq($sformatf("%s_k%0d_gid", tag, k),   32'(gid_o[k]), 32'd0);
            check_eq($sformatf("%s_k%0d_maddr", tag, k), maddr[k], 32'd0);
            check_eq($sformatf("%s_k%0d_mdin", tag, k),  mdin[k], 32'd0);
            check_eq($sformatf("%s_k%0d_rdata0", tag, k), rdata_o[k][0], 32'd0);
            check_eq($sformatf("%s_k%0d_rdata1", tag, k), rdata_o[k][1], 32'd0);
        end
    endtask

    // Compare every output of both instances against the model for cycle cyc.
    task automatic observe();
        bit acc;
        bit rsp;
        for (int k = 0; k < 2; k++) begin
            acc = act[k] && (cyc >= gc[k]) && (cyc < gc[k] + tlen[k]);
            rsp = act[k] && (cyc == gc[k] + tlen[k]);
            if (rsp) begin
                if (twe[k]) ref_mem[k][taddr[k][3:0]] = twd[k];
                else        exp_rd[k][who[k]] = ref_mem[k][taddr[k][3:0]];
                inflight[k][who[k]] = 1'b0;
            end
            for (int i = 0; i < 2; i++) rsp_flag[k][i] = rsp && (int'(who[k]) == i);
            check_eq($sformatf("k%0d_MemRd", k),  32'(mrd[k]), 32'(acc && !twe[k]));
            check_eq($sformatf("k%0d_MemWr", k),  32'(mwr[k]), 32'(acc && twe[k]));
            check_eq($sformatf("k%0d_busy", k),   32'(busy_o[k]), 32'(acc || rsp));
            check_eq($sformatf("k%0d_ack0", k),   32'(ack_o[k][0]), 32'(rsp_flag[k][0]));
            check_eq($sformatf("k%0d_ack1", k),   32'(ack_o[k][1]), 32'(rsp_flag[k][1]));
            check_eq($sformatf("k%0d_grant_id", k), 32'(gid_o[k]), 32'(exp_gid[k]));
            check_eq($sformatf("k%0d_mem_addr", k), maddr[k], exp_addr[k]);
            check_eq($sformatf("k%0d_mem_data_in", k), mdin[k], exp_din[k]);
            check_eq($sformatf("k%0d_r0_rdata", k), rdata_o[k][0], exp_rd[k][0]);
            check_eq($sformatf("k%0d_r1_rdata", k), rdata_o[k][1], exp_rd[k][1]);
            for (int i = 0; i < 2; i++) begin
                if (ack_o[k][i] && ack_n[k] < 8) begin
                    ack_seq[k][ack_n[k]] = i;
                    ack_n[k]++;
                end
            end
        end
    endtask

    task automatic new_fields(input int k, input int i);
        we_d[k][i]    = 1'($urandom_range(0, 1));
        addr_d[k][i]  = $urandom;
        wdata_d[k][i] = $urandom;
    endtask

    // Requester behaviour: drop req on ack, optionally keep it (new command).
    task automatic drive_reqs();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 2; i++) begin
                if (rsp_flag[k][i]) begin
                    if (hold[k][i]) begin
                        req_d[k][i] = 1'b1;
                    end else if (auto_mode && ($urandom_range(0, 3) == 0)) begin
                        req_d[k][i] = 1'b1;
                        new_fields(k, i);
                    end else begin
                        req_d[k][i] = 1'b0;
                    end
                end else if (auto_mode) begin
                    if (inflight[k][i]) begin
                        // Granted: fields and req may change freely now.
                        if ($urandom_range(0, 3) == 0) req_d[k][i] = 1'b0;
                        new_fields(k, i);
                    end else if (!req_d[k][i] && ($urandom_range(0, 2) == 0)) begin
                        req_d[k][i] = 1'b1;
                        new_fields(k, i);
                    end
                end
            end
        end
    endtask

    // Decide what the coming clock edge (cyc+1) grants.
    task automatic decide();
        bit p;
        for (int k = 0; k < 2; k++) begin
            if ((cyc + 1 >= free_c[k]) && (req_d[k][0] || req_d[k][1])) begin
                if (req_d[k][0] && req_d[k][1]) p = !last[k];
                else                            p = req_d[k][1];
                act[k]   = 1'b1;
                gc[k]    = cyc + 1;
                who[k]   = p;
                twe[k]   = we_d[k][p];
                taddr[k] = addr_d[k][p];
                twd[k]   = wdata_d[k][p];
                tlen[k]  = twe[k] ? 1 : lat_of(k);
                free_c[k] = gc[k] + tlen[k] + 2;
                last[k]  = p;
                exp_gid[k]  = p;
                exp_addr[k] = taddr[k];
                exp_din[k]  = twd[k];
                inflight[k][p] = 1'b1;
            end
        end
    endtask

    task automatic step();
        drive_reqs();
        decide();
        @(negedge clk);
        cyc++;
        observe();
    endtask

    function automatic bit model_busy();
        for (int k = 0; k < 2; k++) begin
            if (req_d[k][0] || req_d[k][1]) return 1'b1;
            if (act[k] && (cyc < gc[k] + tlen[k])) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic wait_idle();
        int n;
        n = 0;
        while (model_busy() && n < 80) begin
            step();
            n++;
        end
        check_eq("idle_timeout", 32'(model_busy()), 32'd0);
    endtask

    task automatic set_req(input int i, input bit we, input logic [31:0] a, input logic [31:0] d);
        for (int k = 0; k < 2; k++) begin
            req_d[k][i] = 1'b1; we_d[k][i] = we; addr_d[k][i] = a; wdata_d[k][i] = d;
        end
    endtask

    task automatic clr_req(input int i);
        for (int k = 0; k < 2; k++) req_d[k][i] = 1'b0;
    endtask

    // Reset asserted mid-cycle; outputs must clear at once. Released at the next negedge.
    task automatic do_reset();
        reset = 1'b1;
        #1;
        check_all_zero("rst");
        model_reset();
        @(negedge clk);
        cyc++;
        reset = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        vectors = 0; miscompares = 0; cyc = 0; auto_mode = 1'b0;
        reset = 1'b1; mem_clr = 1'b1;
        for (int k = 0; k < 2; k++) begin
            ack_n[k] = 0;
            for (int j = 0; j < 8; j++) ack_seq[k][j] = -1;
            for (int a = 0; a < 16; a++) ref_mem[k][a] = 32'd0;
            for (int i = 0; i < 2; i++) begin
                req_d[k][i] = 1'b0; we_d[k][i] = 1'b0; hold[k][i] = 1'b0;
                addr_d[k][i] = 32'd0; wdata_d[k][i] = 32'd0;
            end
        end
        model_reset();
        repeat (3) @(negedge clk);
        check_all_zero("por");
        reset = 1'b0; mem_clr = 1'b0;

        // r0 write, then read it back.
        set_req(0, 1'b1, 32'd5, 32'hA5A5);
        wait_idle();
        set_req(0, 1'b0, 32'd5, 32'd0);
        wait_idle();
        repeat (10) step();
        for (int k = 0; k < 2; k++)
            check_eq($sformatf("k%0d_r0_rdata_held", k), rdata_o[k][0], 32'hA5A5);

        // After reset both write while held: grants alternate starting with r0.
        do_reset();
        for (int k = 0; k < 2; k++) begin
            ack_n[k] = 0; hold[k][0] = 1'b1; hold[k][1] = 1'b1;
        end
        set_req(0, 1'b1, 32'd2, 32'h11);
        set_req(1, 1'b1, 32'd3, 32'h22);
        for (int n = 0; n < 60 && (ack_n[0] < 4 || ack_n[1] < 4); n++) step();
        for (int k = 0; k < 2; k++) begin
            hold[k][0] = 1'b0; hold[k][1] = 1'b0;
        end
        wait_idle();
        for (int k = 0; k < 2; k++)
            for (int j = 0; j < 4; j++)
                check_eq($sformatf("k%0d_grant_order%0d", k, j), 32'(ack_seq[k][j]), 32'(j % 2));

        // r1 reads addr 3; r0 rdata untouched.
        set_req(1, 1'b0, 32'd3, 32'd0);
        wait_idle();
        for (int k = 0; k < 2; k++) begin
            check_eq($sformatf("k%0d_r1_read3", k), rdata_o[k][1], 32'h22);
            check_eq($sformatf("k%0d_r0_untouched", k), rdata_o[k][0], 32'd0);
        end

        // Reset during an r0 write ACCESS; pending r1 read granted right after.
        set_req(0, 1'b1, 32'd3, 32'hDEAD);
        step();
        clr_req(0);
        set_req(1, 1'b0, 32'd3, 32'd0);
        do_reset();
        step();
        for (int k = 0; k < 2; k++) begin
            check_eq($sformatf("k%0d_post_rst_busy", k), 32'(busy_o[k]), 32'd1);
            check_eq($sformatf("k%0d_post_rst_gid", k), 32'(gid_o[k]), 32'd1);
        end
        wait_idle();
        for (int k = 0; k < 2; k++)
            check_eq($sformatf("k%0d_aborted_write", k), rdata_o[k][1], 32'h22);

        // r0 drops req during a read ACCESS: exactly one ack.
        for (int k = 0; k < 2; k++) ack_n[k] = 0;
        set_req(0, 1'b0, 32'd2, 32'd0);
        step();
        clr_req(0);
        wait_idle();
        repeat (4) step();
        for (int k = 0; k < 2; k++) begin
            check_eq($sformatf("k%0d_drop_acks", k), 32'(ack_n[k]), 32'd1);
            check_eq($sformatf("k%0d_drop_rdata", k), rdata_o[k][0], 32'h11);
        end

        // Randomized traffic.
        auto_mode = 1'b1;
        repeat (3000) step();
        auto_mode = 1'b0;
        clr_req(0);
        clr_req(1);
        wait_idle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
